matrix_elementwise_alu: RTL and testbench

- Parametrised successor to the fixed 4x4 8-bit matrix subtractor.
- Computes an element-wise operation c = f(a, b) over a ROWS x COLS matrix. f is selectable as add, wrapping subtract, saturating subtract or absolute difference.
- Processes LANES elements per clock, uses a start/busy/done handshake, and raises a sticky negative-result flag.
- Sits between the operand buffers and the result buffer in the NPU matrix datapath.

---
 rtl/matrix_elementwise_alu.sv | 141 ++++++++++++++
 tb/tb_matrix_elementwise_alu.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_elementwise_alu.sv
// Element-wise matrix ALU: c = f(a, b) over a ROWS x COLS matrix, LANES elements per clock.
// Start/busy/done handshake; c updates atomically on completion; sticky a<b flag.
module matrix_elementwise_alu #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int LANES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [1:0]                  mode,
    input  logic [ROWS*COLS*IN_W-1:0]   a,
    input  logic [ROWS*COLS*IN_W-1:0]   b,
    output logic [ROWS*COLS*OUT_W-1:0]  c,
    output logic                        busy,
    output logic                        done,
    output logic                        neg_flag
);

    localparam int N     = ROWS * COLS;
    localparam int BEATS = N / LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_ADD      = 2'd0;
    localparam logic [1:0] M_SUB      = 2'd1;
    localparam logic [1:0] M_SUB_SAT  = 2'd2;

    generate
        if (OUT_W < IN_W + 1) begin : g_bad_out_w
            $error("matrix_elementwise_alu: OUT_W must be >= IN_W+1");
        end
        if (LANES < 1 || (N % LANES) != 0) begin : g_bad_lanes
            $error("matrix_elementwise_alu: LANES must divide ROWS*COLS");
        end
    endgenerate

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N*IN_W-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]         mode_q, mode_d;
    logic [N*OUT_W-1:0] res_q, res_d;
    logic [N*OUT_W-1:0] c_q, c_d;
    logic               neg_q, neg_d;

    int               elem_idx;
    logic [OUT_W-1:0] elem_a, elem_b, elem_diff;
    logic             elem_lt;

    always_comb begin
        // NOTE: every _d starts from its _q (and every temporary from a constant) so no path leaves a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        res_d     = res_q;
        c_d       = c_q;
        neg_d     = neg_q;
        elem_idx  = 0;
        elem_a    = '0;
        elem_b    = '0;
        elem_diff = '0;
        elem_lt   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    mode_d  = mode;
                    cnt_d   = '0;
                    res_d   = '0;
                    neg_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    elem_idx  = int'(cnt_q) * LANES + l;
                    elem_a    = OUT_W'(a_q[elem_idx*IN_W +: IN_W]);
                    elem_b    = OUT_W'(b_q[elem_idx*IN_W +: IN_W]);
                    elem_diff = elem_a - elem_b;
                    elem_lt   = elem_a < elem_b;
                    case (mode_q)
                        M_ADD:     res_d[elem_idx*OUT_W +: OUT_W] = elem_a + elem_b;
                        M_SUB:     res_d[elem_idx*OUT_W +: OUT_W] = elem_diff;
                        M_SUB_SAT: res_d[elem_idx*OUT_W +: OUT_W] = elem_lt ? '0 : elem_diff;
                        default:   res_d[elem_idx*OUT_W +: OUT_W] = elem_lt ? (elem_b - elem_a) : elem_diff;
                    endcase
                    if (mode_q != M_ADD && elem_lt) begin
                        neg_d = 1'b1;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                // Last beat: publish the completed result in one step.
                if (cnt_q == CNT_W'(BEATS - 1)) begin
                    c_d     = res_d;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            c_q     <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            c_q     <= c_d;
            neg_q   <= neg_d;
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on start before RUN reads them.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        mode_q <= mode_d;
    end

    assign c        = c_q;
    assign busy     = (state_q == S_RUN) || (state_q == S_DONE);
    assign done     = (state_q == S_DONE);
    assign neg_flag = neg_q;

endmodule

// File: tb/tb_matrix_elementwise_alu.sv
// Scoreboard bench for matrix_elementwise_alu: four configurations run side by side, each with
// directed cases, a mid-run reset, a held start and random jobs checked against a plain-arithmetic model.
module tb_matrix_elementwise_alu;

    localparam int NCFG = 4;
    localparam int JOBS = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int n_fin    = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int cfg_rows(input int g);
        return (g == 3) ? 3 : 4;
    endfunction
    function automatic int cfg_cols(input int g);
        return (g == 3) ? 5 : 4;
    endfunction
    function automatic int cfg_lanes(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 16;
            default: return 5;
        endcase
    endfunction

    generate
        for (genvar g = 0; g < NCFG; g++) begin : g_cfg
            localparam int R  = cfg_rows(g);
            localparam int C  = cfg_cols(g);
            localparam int L  = cfg_lanes(g);
            localparam int N  = R * C;
            localparam int BE = N / L;

            logic              rst;
            logic              start;
            logic [1:0]        mode;
            logic [N*8-1:0]    a, b;
            logic [N*16-1:0]   c;
            logic              busy, done, neg;

            logic [N*16-1:0]   exp_c_q[$];
            logic              exp_neg_q[$];
            int                exp_cyc_q[$];

            logic [N*16-1:0]   mon_c;
            logic              mon_neg;
            int                mon_t0;
            logic [N*8-1:0]    ta, tb_v;
            int                bc;
            int                last_acc;

            matrix_elementwise_alu #(
                .ROWS(R), .COLS(C), .IN_W(8), .OUT_W(16), .LANES(L)
            ) dut (
                .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
                .c(c), .busy(busy), .done(done), .neg_flag(neg)
            );

            function automatic string nm(input string s);
                return $sformatf("cfg%0d_%s", g, s);
            endfunction

            // Reference: element-by-element integer arithmetic.
            function automatic void model(input logic [1:0] m, input logic [N*8-1:0] av,
                                          input logic [N*8-1:0] bv,
                                          output logic [N*16-1:0] rc, output logic rn);
                rc = '0;
                rn = 1'b0;
                for (int e = 0; e < N; e++) begin
                    int x, y, r;
                    x = int'(av[e*8 +: 8]);
                    y = int'(bv[e*8 +: 8]);
                    case (m)
                        2'd0:    r = x + y;
                        2'd1:    r = (x - y + 65536) % 65536;
                        2'd2:    r = (x >= y) ? x - y : 0;
                        default: r = (x >= y) ? x - y : y - x;
                    endcase
                    rc[e*16 +: 16] = 16'(r);
                    if (m != 2'd0 && x < y) rn = 1'b1;
                end
            endfunction

            function automatic logic [N*8-1:0] rnd_vec();
                logic [N*8-1:0] v;
                for (int e = 0; e < N; e++) v[e*8 +: 8] = 8'($urandom);
                return v;
            endfunction

            task automatic issue(input logic [1:0] m, input logic [N*8-1:0] av, input logic [N*8-1:0] bv);
                logic [N*16-1:0] rc;
                logic            rn;
                model(m, av, bv, rc, rn);
                exp_c_q.push_back(rc);
                exp_neg_q.push_back(rn);
                exp_cyc_q.push_back(cyc);
                start = 1'b1;
                mode  = m;
                a     = av;
                b     = bv;
            endtask

            task automatic wait_idle();
                for (int n = 0; n < BE + 20 && busy; n++) @(negedge clk);
                check(nm("idle_reached"), 512'(busy), 512'(0));
            endtask

            // Issue one job from IDLE, scramble inputs during RUN, wait for completion.
            task automatic run_job(input logic [1:0] m, input logic [N*8-1:0] av,
                                   input logic [N*8-1:0] bv, output int busy_cyc);
                issue(m, av, bv);
                @(negedge clk);
                start = 1'b0;
                mode  = 2'($urandom);
                a     = rnd_vec();
                b     = rnd_vec();
                busy_cyc = 0;
                for (int n = 0; n < BE + 20 && busy; n++) begin
                    busy_cyc++;
                    @(negedge clk);
                end
                check(nm("job_end_idle"), 512'(busy), 512'(0));
            endtask

            always @(negedge clk) begin
                if (!rst && done) begin
                    check(nm("done_has_job"), 512'(exp_c_q.size() > 0), 512'(1));
                    if (exp_c_q.size() > 0) begin
                        mon_c   = exp_c_q.pop_front();
                        mon_neg = exp_neg_q.pop_front();
                        mon_t0  = exp_cyc_q.pop_front();
                        check(nm("result_c"), 512'(c), 512'(mon_c));
                        check(nm("neg_flag"), 512'(neg), 512'(mon_neg));
                        check(nm("latency"), 512'(cyc - mon_t0), 512'(BE + 1));
                    end
                end
            end

            initial begin
                rst   = 1'b1;
                start = 1'b0;
                mode  = 2'd0;
                a     = '0;
                b     = '0;
                repeat (3) @(negedge clk);
                check(nm("rst_c"), 512'(c), 512'(0));
                check(nm("rst_busy"), 512'(busy), 512'(0));
                check(nm("rst_done"), 512'(done), 512'(0));
                check(nm("rst_neg"), 512'(neg), 512'(0));
                rst = 1'b0;
                @(negedge clk);

                // SUB 200-55 everywhere
                for (int e = 0; e < N; e++) begin
                    ta[e*8 +: 8]   = 8'd200;
                    tb_v[e*8 +: 8] = 8'd55;
                end
                run_job(2'd1, ta, tb_v, bc);
                check(nm("sub_busy_cycles"), 512'(bc), 512'(BE + 1));
                check(nm("sub_c_first"), 512'(c[15:0]), 512'(145));
                check(nm("sub_c_last"), 512'(c[N*16-1 -: 16]), 512'(145));
                check(nm("sub_neg"), 512'(neg), 512'(0));

                // Reset in the middle of RUN discards the job
                start = 1'b1;
                mode  = 2'd1;
                a     = rnd_vec();
                b     = rnd_vec();
                @(negedge clk);
                start = 1'b0;
                repeat ((BE >= 3) ? 2 : 0) @(negedge clk);
                rst = 1'b1;
                #1;
                check(nm("midrst_busy"), 512'(busy), 512'(0));
                check(nm("midrst_done"), 512'(done), 512'(0));
                check(nm("midrst_c"), 512'(c), 512'(0));
                check(nm("midrst_neg"), 512'(neg), 512'(0));
                #99;
                rst = 1'b0;
                repeat (BE + 3) @(negedge clk);
                check(nm("postrst_busy"), 512'(busy), 512'(0));

                // Borrow on element (0,0) under the three subtract modes
                ta   = '0;
                tb_v = '0;
                ta[7:0]   = 8'd3;
                tb_v[7:0] = 8'd5;
                run_job(2'd1, ta, tb_v, bc);
                check(nm("sub_wrap_c00"), 512'(c[15:0]), 512'(16'hFFFE));
                check(nm("sub_wrap_c01"), 512'(c[31:16]), 512'(0));
                check(nm("sub_wrap_neg"), 512'(neg), 512'(1));
                run_job(2'd2, ta, tb_v, bc);
                check(nm("sub_sat_c00"), 512'(c[15:0]), 512'(0));
                check(nm("sub_sat_neg"), 512'(neg), 512'(1));
                run_job(2'd3, ta, tb_v, bc);
                check(nm("abs_c00"), 512'(c[15:0]), 512'(2));
                check(nm("abs_neg"), 512'(neg), 512'(1));

                // ADD at full scale
                ta   = '1;
                tb_v = '1;
                run_job(2'd0, ta, tb_v, bc);
                check(nm("add_c_first"), 512'(c[15:0]), 512'(510));
                check(nm("add_c_last"), 512'(c[N*16-1 -: 16]), 512'(510));
                check(nm("add_neg"), 512'(neg), 512'(0));

                // start held high: accepted on each IDLE cycle, inputs churn during RUN
                last_acc = -1;
                for (int i = 0; i < 20; i++) begin
                    if (!busy) begin
                        if (last_acc >= 0) check(nm("job_spacing"), 512'(cyc - last_acc), 512'(BE + 2));
                        last_acc = cyc;
                        issue(2'($urandom), rnd_vec(), rnd_vec());
                    end else begin
                        start = 1'b1;
                        mode  = 2'($urandom);
                        a     = rnd_vec();
                        b     = rnd_vec();
                    end
                    @(negedge clk);
                end
                start = 1'b0;
                wait_idle();

                // Random jobs; a quarter force b<=a per element so neg_flag=0 gets exercised
                for (int j = 0; j < JOBS; j++) begin
                    ta   = rnd_vec();
                    tb_v = rnd_vec();
                    if ($urandom_range(0, 3) == 0) tb_v = ta & tb_v;
                    run_job(2'($urandom), ta, tb_v, bc);
                end

                @(negedge clk);
                check(nm("scoreboard_drained"), 512'(exp_c_q.size()), 512'(0));
                n_fin = n_fin + 1;
            end
        end
    endgenerate

    initial begin
        int n;
        n = 0;
        while (n_fin < NCFG && n < 60000) begin
            @(negedge clk);
            n++;
        end
        check("all_configs_finished", 512'(n_fin), 512'(NCFG));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
